dram_host_initiator: RTL and testbench
======================================

# dram_host_initiator

Host-side initiator for the on-chip DRAM controller's CPU bus (CSn/RWn/CONFn/address/RDY). Holds the controller in reset and then programs it with the 11-word configuration sequence. After configuration it converts a valid/ready request stream into single bus accesses, one at a time. It also drives and captures the byte-wide data path through the controller's external latches, and sits between the SoC fabric and the controller's pins.

## Interface
Parameters:
- RST_CYCLES, 8: cycles `mem_rst_n_o` stays low after `reset` deasserts.
- TIMEOUT_CYCLES, 1023: maximum busy cycles per access before an error completion.

Ports:
- clk_i  in  1  clock; controller runs on the same clock, so there are no synchronisers.
- reset  in  1  synchronous, active-high.
- req_valid_i / req_ready_o  in/out  1  request handshake; transfer occurs on a cycle with both high.
- req_we_i  in  1  1 = write.
- req_addr_i  in  18  word address.
- req_wdata_i  in  8  write data.
- rsp_valid_o  out  1  one-cycle completion pulse, for both reads and writes.
- rsp_rdata_o  out  8  read data; valid with `rsp_valid_o`.
- rsp_err_o  out  1  timeout flag; valid with `rsp_valid_o`.
- cfg_refresh_i  in  16  refresh interval.
- cfg_mode_i  in  8  mode byte. Bit 4 = RDY polarity.
- cfg_delay_i  in  56  seven delay bytes, low byte first, in this order: setup, hold, ras, cas, ras2cas, ras_pre, cas_pre.
- cfg_done_o  out  1  high once configuration is complete.
- mem_rst_n_o, mem_cs_n_o, mem_rw_n_o, mem_conf_n_o  out  1  controller pins.
- mem_addr_o  out  18  controller address.
- mem_rdy_i  in  1  controller RDY pin (raw, polarity not applied).
- mem_dq_o  out  8  write data.
- mem_dq_oe_o  out  1  write data enable.
- mem_rdata_i  in  8  read-latch output.

## Operation
- Reset values of outputs:
  - Low: `mem_rst_n_o`, `req_ready_o`, `rsp_valid_o`, `rsp_err_o`, `cfg_done_o`, `mem_dq_oe_o`.
  - High: `mem_cs_n_o`, `mem_rw_n_o`, `mem_conf_n_o`.
  - All zeros: `mem_addr_o`, `mem_dq_o`, `rsp_rdata_o`.
  - Internal: `pol` = 0.
- RST_HOLD: counts RST_CYCLES, then sets `mem_rst_n_o`=1 and goes to CFG_LO with index i=0.
- CFG_LO: drives `mem_cs_n_o`=0, `mem_conf_n_o`=0, `mem_addr_o[7:0]`=word[i] (upper address bits 0) for one cycle, then goes to CFG_HI.
  - Words in order: refresh[7:0], refresh[15:8], mode, the seven delay bytes, then a final word.
  - Mode word (i=2): forced to `cfg_mode_i`. `pol` loads `cfg_mode_i[4]` on the same edge.
  - Final word: fixed 8'h00. This locks configuration, keeps A17 on its own pin and disables pause-on-refresh.
- CFG_HI: drives `mem_cs_n_o`=1, `mem_conf_n_o`=1 for one cycle. If i=10, goes to IDLE and sets `cfg_done_o`; otherwise i++ and returns to CFG_LO.
- `cfg_*` inputs must be stable from `reset` deassertion until `cfg_done_o`.
- Decoded ready: `rdy` = `mem_rdy_i` ^ `pol`. `rdy`=1 means the controller is idle.
- IDLE: `req_ready_o` = `rdy`. On a handshake the block registers:
  - `mem_cs_n_o`=0, `mem_rw_n_o`=~we, `mem_addr_o`=addr.
  - `mem_dq_o`=wdata, `mem_dq_oe_o`=we.
  - Then goes to ACC_WAIT with the timeout counter at 0.
- ACC_WAIT: CSn is held low.
  - The first edge in this state is ignored, because the controller drops RDY combinationally.
  - From the second edge, the first sampled `rdy`=1 ends the access: CSn=1, `mem_dq_oe_o`=0, go to ACC_GAP.
  - If the counter reaches TIMEOUT_CYCLES: same exit, with the error flag set.
- ACC_GAP: one cycle. Captures `mem_rdata_i` into `rsp_rdata_o` (reads only; held otherwise), pulses `rsp_valid_o` with `rsp_err_o`, and returns to IDLE.
  - This guarantees CSn stays high for at least 2 cycles between accesses, which clears the controller's held-CSn flag.
- Only one access is outstanding at a time. No new request is accepted until ACC_GAP completes.
- `reset` asserted mid-access or mid-configuration: every state and output returns to its reset value on the next edge. The controller is reset through `mem_rst_n_o`. Any in-flight response is dropped.

## Timing
- Request accepted at edge T0.
- CSn falls after T0. The earliest end edge is T0+2, so the earliest `rsp_valid_o` is at T0+3.
- Actual latency = controller access time + 2 cycles.
- Configuration takes RST_CYCLES + 22 cycles after `reset` deasserts.
- `req_ready_o` is combinational from `mem_rdy_i` and the state; it is never high outside IDLE.

## Structure
- Shared package `dram_if_pkg` contains:
  - State enum: RST_HOLD, CFG_LO, CFG_HI, IDLE, ACC_WAIT, ACC_GAP.
  - Configuration word index constants 0..10.
  - Mode bit positions (polarity = 4, page mode = 5, data setup = 6, delay RDY = 7).
  - Final-word constant 8'h00.
- No sub-module. The configuration word mux is an inline case on i.

## Test plan
- Reset release with RST_CYCLES=8, refresh=16'h0123, mode=8'h17 → `mem_rst_n_o` rises at cycle 8. Eleven CSn/CONFn pulses carry 23, 01, 17, the delay bytes, then 00. `cfg_done_o` rises at cycle 30.
- Write addr 18'h2ABCD, data 8'h5A; controller model busy for 6 cycles → CSn low through the end edge. `mem_dq_oe_o`=1 with 5A for the whole window. One `rsp_valid_o` with `rsp_err_o`=0.
- Read with mode bit 4=1 (inverted RDY) and latch data 8'hC3 → `rsp_rdata_o`=C3. CSn high for 2 cycles before the next back-to-back request is accepted.
- Model never returns ready, TIMEOUT_CYCLES=15 → CSn released after 15 busy cycles. `rsp_valid_o` with `rsp_err_o`=1. The next request succeeds normally.
- `reset` asserted on the 3rd ACC_WAIT cycle → CSn=1, `mem_rst_n_o`=0 next cycle. No `rsp_valid_o`. The full configuration sequence reruns.

Source files
------------

// File: rtl/dram_if_pkg.sv
// Shared types and constants for the DRAM controller host initiator:
// FSM states, configuration word indices, mode-byte bit positions.
package dram_if_pkg;

   typedef enum logic [2:0] {
      RST_HOLD,
      CFG_LO,
      CFG_HI,
      IDLE,
      ACC_WAIT,
      ACC_GAP
   } state_t;

   // Order in which configuration words are presented on the address bus.
   typedef enum logic [3:0] {
      CFG_REF_LO  = 4'd0,
      CFG_REF_HI  = 4'd1,
      CFG_MODE    = 4'd2,
      CFG_SETUP   = 4'd3,
      CFG_HOLD    = 4'd4,
      CFG_RAS     = 4'd5,
      CFG_CAS     = 4'd6,
      CFG_RAS2CAS = 4'd7,
      CFG_RAS_PRE = 4'd8,
      CFG_CAS_PRE = 4'd9,
      CFG_FINAL   = 4'd10
   } cfg_idx_t;

   typedef enum int {
      MODE_POL     = 4,
      MODE_PAGE    = 5,
      MODE_DSETUP  = 6,
      MODE_DLY_RDY = 7
   } mode_bit_t;

   // Locks configuration, keeps A17 on its own pin, no pause-on-refresh.
   localparam logic [7:0] CFG_FINAL_WORD = 8'h00;

endpackage

// File: rtl/dram_host_initiator_if.sv
// Request/response stream between the SoC fabric (master) and the
// DRAM host initiator (slave).
interface dram_host_initiator_if;

   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [17:0] req_addr_i;
   logic [7:0]  req_wdata_i;
   logic        rsp_valid_o;
   logic [7:0]  rsp_rdata_o;
   logic        rsp_err_o;

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
   );

endinterface

// File: rtl/dram_host_initiator.sv
// Host-side initiator for the DRAM controller CPU bus: reset hold, 11-word
// configuration, then one-at-a-time single accesses with timeout.
module dram_host_initiator
   import dram_if_pkg::*;
#(
   parameter int RST_CYCLES     = 8,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic        clk_i,
   input  logic        reset,
   dram_host_initiator_if.slave req_if,
   input  logic [15:0] cfg_refresh_i,
   input  logic [7:0]  cfg_mode_i,
   input  logic [55:0] cfg_delay_i,
   output logic        cfg_done_o,
   output logic        mem_rst_n_o,
   output logic        mem_cs_n_o,
   output logic        mem_rw_n_o,
   output logic        mem_conf_n_o,
   output logic [17:0] mem_addr_o,
   input  logic        mem_rdy_i,
   output logic [7:0]  mem_dq_o,
   output logic        mem_dq_oe_o,
   input  logic [7:0]  mem_rdata_i
);

   localparam int RCW = $clog2(RST_CYCLES + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   state_t         state;
   logic [RCW-1:0] rst_cnt;
   logic [TCW-1:0] to_cnt;
   logic [3:0]     cfg_idx;
   logic [3:0]     nxt_idx;
   logic [7:0]     cfg_word;
   logic           pol;
   logic           rdy;
   logic           acc_err;
   logic           rsp_valid_q;
   logic           rsp_err_q;
   logic [7:0]     rsp_rdata_q;

   assign rdy                = mem_rdy_i ^ pol;
   assign req_if.req_ready_o = (state == IDLE) && rdy;
   assign req_if.rsp_valid_o = rsp_valid_q;
   assign req_if.rsp_err_o   = rsp_err_q;
   assign req_if.rsp_rdata_o = rsp_rdata_q;

   // Index of the word about to be driven when entering CFG_LO.
   always_comb begin
      nxt_idx = CFG_REF_LO;
      if (state == CFG_HI) begin
         nxt_idx = cfg_idx + 4'd1;
      end
   end

   always_comb begin
      cfg_word = CFG_FINAL_WORD;
      case (nxt_idx)
         CFG_REF_LO:  cfg_word = cfg_refresh_i[7:0];
         CFG_REF_HI:  cfg_word = cfg_refresh_i[15:8];
         CFG_MODE:    cfg_word = cfg_mode_i;
         CFG_SETUP:   cfg_word = cfg_delay_i[7:0];
         CFG_HOLD:    cfg_word = cfg_delay_i[15:8];
         CFG_RAS:     cfg_word = cfg_delay_i[23:16];
         CFG_CAS:     cfg_word = cfg_delay_i[31:24];
         CFG_RAS2CAS: cfg_word = cfg_delay_i[39:32];
         CFG_RAS_PRE: cfg_word = cfg_delay_i[47:40];
         CFG_CAS_PRE: cfg_word = cfg_delay_i[55:48];
         default:     cfg_word = CFG_FINAL_WORD;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state        <= RST_HOLD;
         rst_cnt      <= '0;
         to_cnt       <= '0;
         cfg_idx      <= '0;
         pol          <= 1'b0;
         acc_err      <= 1'b0;
         cfg_done_o   <= 1'b0;
         mem_rst_n_o  <= 1'b0;
         mem_cs_n_o   <= 1'b1;
         mem_rw_n_o   <= 1'b1;
         mem_conf_n_o <= 1'b1;
         mem_addr_o   <= '0;
         mem_dq_o     <= '0;
         mem_dq_oe_o  <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_rdata_q  <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state)
            RST_HOLD: begin
               if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
                  mem_rst_n_o  <= 1'b1;
                  cfg_idx      <= nxt_idx;
                  mem_cs_n_o   <= 1'b0;
                  mem_conf_n_o <= 1'b0;
                  mem_addr_o   <= {10'd0, cfg_word};
                  state        <= CFG_LO;
               end else begin
                  rst_cnt <= rst_cnt + RCW'(1);
               end
            end
            CFG_LO: begin
               mem_cs_n_o   <= 1'b1;
               mem_conf_n_o <= 1'b1;
               state        <= CFG_HI;
            end
            CFG_HI: begin
               if (cfg_idx == CFG_FINAL) begin
                  cfg_done_o <= 1'b1;
                  state      <= IDLE;
               end else begin
                  cfg_idx      <= nxt_idx;
                  mem_cs_n_o   <= 1'b0;
                  mem_conf_n_o <= 1'b0;
                  mem_addr_o   <= {10'd0, cfg_word};
                  // RDY polarity takes effect as soon as the mode word goes out.
                  if (nxt_idx == CFG_MODE) begin
                     pol <= cfg_mode_i[MODE_POL];
                  end
                  state <= CFG_LO;
               end
            end
            IDLE: begin
               if (req_if.req_valid_i && rdy) begin
                  mem_cs_n_o  <= 1'b0;
                  mem_rw_n_o  <= ~req_if.req_we_i;
                  mem_addr_o  <= req_if.req_addr_i;
                  mem_dq_o    <= req_if.req_wdata_i;
                  mem_dq_oe_o <= req_if.req_we_i;
                  to_cnt      <= '0;
                  state       <= ACC_WAIT;
               end
            end
            ACC_WAIT: begin
               // to_cnt == 0 marks the first edge, where RDY is still stale.
               if ((to_cnt != '0) && rdy) begin
                  mem_cs_n_o  <= 1'b1;
                  mem_dq_oe_o <= 1'b0;
                  acc_err     <= 1'b0;
                  state       <= ACC_GAP;
               end else if (to_cnt == TCW'(TIMEOUT_CYCLES - 1)) begin
                  mem_cs_n_o  <= 1'b1;
                  mem_dq_oe_o <= 1'b0;
                  acc_err     <= 1'b1;
                  state       <= ACC_GAP;
               end else begin
                  to_cnt <= to_cnt + TCW'(1);
               end
            end
            ACC_GAP: begin
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= acc_err;
               if (mem_rw_n_o) begin
                  rsp_rdata_q <= mem_rdata_i;
               end
               state <= IDLE;
            end
            default: state <= RST_HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_host_initiator.sv
// Bench for dram_host_initiator: behavioural controller model plus directed
// and randomized accesses checked against arithmetic timing expectations.
module tb_dram_host_initiator;

   localparam int RST_C = 8;
   localparam int TO_C  = 15;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] cfg_refresh = '0;
   logic [7:0]  cfg_mode = '0;
   logic [55:0] cfg_delay = '0;
   logic        cfg_done;
   logic        mem_rst_n, mem_cs_n, mem_rw_n, mem_conf_n;
   logic [17:0] mem_addr;
   logic        mem_rdy;
   logic [7:0]  mem_dq;
   logic        mem_dq_oe;
   logic [7:0]  mem_rdata = '0;

   int   errors = 0;
   int   checks = 0;
   int   busy_len = 1;
   int   busy_cnt = 0;
   logic pol_m = 1'b0;
   int   rsp_pulses = 0;
   int   exp_rsps = 0;
   logic [7:0] last_rd = '0;

   dram_host_initiator_if rif ();

   dram_host_initiator #(.RST_CYCLES(RST_C), .TIMEOUT_CYCLES(TO_C)) dut (
      .clk_i(clk), .reset(reset), .req_if(rif),
      .cfg_refresh_i(cfg_refresh), .cfg_mode_i(cfg_mode), .cfg_delay_i(cfg_delay),
      .cfg_done_o(cfg_done), .mem_rst_n_o(mem_rst_n), .mem_cs_n_o(mem_cs_n),
      .mem_rw_n_o(mem_rw_n), .mem_conf_n_o(mem_conf_n), .mem_addr_o(mem_addr),
      .mem_rdy_i(mem_rdy), .mem_dq_o(mem_dq), .mem_dq_oe_o(mem_dq_oe),
      .mem_rdata_i(mem_rdata)
   );

   always #5 clk = ~clk;

   // Controller model: busy from the moment CSn falls, idle again after
   // busy_len edges with CSn low; RDY pin carries the programmed polarity.
   always @(posedge clk) busy_cnt <= mem_cs_n ? 0 : busy_cnt + 1;
   assign mem_rdy = (mem_cs_n | (busy_cnt >= busy_len)) ^ pol_m;

   always @(negedge clk) if (rif.rsp_valid_o === 1'b1) rsp_pulses++;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_config(input logic [15:0] refr, input logic [7:0] mode, input logic [55:0] dly);
      logic [7:0]  exp_w [11];
      logic [17:0] w_addr [$];
      int          w_k [$];
      int          rst_k, done_k;
      logic        ready_bad;
      cfg_refresh = refr;
      cfg_mode    = mode;
      cfg_delay   = dly;
      pol_m       = mode[4];
      last_rd     = '0;
      exp_w[0] = refr[7:0];
      exp_w[1] = refr[15:8];
      exp_w[2] = mode;
      for (int j = 0; j < 7; j++) exp_w[3+j] = dly[8*j +: 8];
      exp_w[10] = 8'h00;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_low_outs", {mem_rst_n, rif.req_ready_o, rif.rsp_valid_o, rif.rsp_err_o, cfg_done, mem_dq_oe}, 64'd0);
      check("rst_high_outs", {mem_cs_n, mem_rw_n, mem_conf_n}, 64'd7);
      check("rst_zero_buses", {mem_addr, mem_dq, rif.rsp_rdata_o}, 64'd0);
      reset = 1'b0;
      rst_k = -1; done_k = -1; ready_bad = 1'b0;
      for (int k = 1; k <= RST_C + 40 && done_k < 0; k++) begin
         @(negedge clk);
         if (rst_k < 0 && mem_rst_n === 1'b1) rst_k = k;
         if (mem_cs_n === 1'b0 && mem_conf_n === 1'b0) begin
            w_addr.push_back(mem_addr);
            w_k.push_back(k);
         end
         if (rif.req_ready_o === 1'b1 && cfg_done !== 1'b1) ready_bad = 1'b1;
         if (cfg_done === 1'b1) done_k = k;
      end
      check("mem_rst_rise_cycle", 64'(rst_k), 64'(RST_C));
      check("cfg_done_cycle", 64'(done_k), 64'(RST_C + 22));
      check("cfg_pulse_count", 64'(w_addr.size()), 64'd11);
      for (int j = 0; j < 11 && j < w_addr.size(); j++)
         check($sformatf("cfg_word%0d", j), {32'(w_k[j]), 14'd0, w_addr[j]},
               {32'(RST_C + 2*j), 14'd0, 10'd0, exp_w[j]});
      check("ready_during_cfg", 64'(ready_bad), 64'd0);
   endtask

   // Expects to be entered at a negedge with the DUT idle.
   task automatic run_access(input logic we, input logic [17:0] a, input logic [7:0] wd,
                             input int lat, input logic [7:0] rd);
      int   e, rsp_k, cs_low;
      logic exp_err, bad_bus, ready_bad, gap0, gap1, got_err;
      logic [7:0] got_rd;
      busy_len  = lat;
      mem_rdata = rd;
      e       = (lat + 1 < TO_C) ? lat + 1 : TO_C;
      exp_err = (lat + 1 > TO_C);
      check("ready_idle", 64'(rif.req_ready_o), 64'd1);
      rif.req_valid_i = 1'b1;
      rif.req_we_i    = we;
      rif.req_addr_i  = a;
      rif.req_wdata_i = wd;
      @(negedge clk);
      rif.req_valid_i = 1'b0;
      rsp_k = -1; cs_low = 0; bad_bus = 1'b0; ready_bad = 1'b0;
      gap0 = 1'b0; gap1 = 1'b0; got_err = 1'b0; got_rd = '0;
      for (int k = 0; k <= TO_C + 4 && rsp_k < 0; k++) begin
         if (k > 0) @(negedge clk);
         if (mem_cs_n === 1'b0) begin
            cs_low++;
            if (mem_dq_oe !== we || (we && mem_dq !== wd) || mem_addr !== a || mem_rw_n !== ~we)
               bad_bus = 1'b1;
         end
         if (k == e) gap0 = mem_cs_n & ~mem_dq_oe;
         if (k == e + 1) gap1 = mem_cs_n;
         if (rif.req_ready_o !== 1'b0 && k <= e) ready_bad = 1'b1;
         if (rif.rsp_valid_o === 1'b1) begin
            rsp_k   = k;
            got_err = rif.rsp_err_o;
            got_rd  = rif.rsp_rdata_o;
         end
      end
      if (!we) last_rd = rd;
      exp_rsps++;
      check("rsp_cycle", 64'(rsp_k), 64'(e + 1));
      check("cs_low_cycles", 64'(cs_low), 64'(e));
      check("bus_during_access", 64'(bad_bus), 64'd0);
      check("cs_high_gap", {gap0, gap1}, 64'd3);
      check("ready_while_busy", 64'(ready_bad), 64'd0);
      check("rsp_err", 64'(got_err), 64'(exp_err));
      check("rsp_rdata", 64'(got_rd), 64'(last_rd));
   endtask

   task automatic random_accesses(input int n);
      for (int j = 0; j < n; j++)
         run_access(1'($urandom), 18'($urandom), 8'($urandom),
                    int'($urandom_range(12, 1)), 8'($urandom));
   endtask

   initial begin
      logic [63:0] r;
      rif.req_valid_i = 1'b0;
      rif.req_we_i    = 1'b0;
      rif.req_addr_i  = '0;
      rif.req_wdata_i = '0;

      run_config(16'h0123, 8'h17, 56'h77_66_55_44_33_22_11);
      run_access(1'b1, 18'h2ABCD, 8'h5A, 6, 8'h00);
      run_access(1'b0, 18'h01234, 8'h00, 3, 8'hC3);
      run_access(1'b0, 18'h3FFFF, 8'h00, 1, 8'h3C);
      run_access(1'b0, 18'h00042, 8'h00, 1000, 8'h99);
      run_access(1'b1, 18'h10101, 8'hA7, 2, 8'h00);
      random_accesses(6);

      // Reset on the third ACC_WAIT cycle drops the access.
      busy_len = 10;
      check("ready_before_abort", 64'(rif.req_ready_o), 64'd1);
      rif.req_valid_i = 1'b1;
      rif.req_we_i    = 1'b1;
      rif.req_addr_i  = 18'h15555;
      rif.req_wdata_i = 8'hEE;
      @(negedge clk);
      rif.req_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_cs_n", 64'(mem_cs_n), 64'd1);
      check("abort_mem_rst_n", 64'(mem_rst_n), 64'd0);
      check("abort_rsp_valid", 64'(rif.rsp_valid_o), 64'd0);

      r = {$urandom(), $urandom()};
      run_config(16'($urandom), 8'($urandom) & 8'hEF, r[55:0]);
      random_accesses(6);
      run_access(1'b0, 18'h2AAAA, 8'h00, 14, 8'h81);

      @(negedge clk);
      check("rsp_pulse_total", 64'(rsp_pulses), 64'(exp_rsps));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
